// File: rtl/derial_pkg.sv
// derial_pkg: definitions shared by the derial transmitter and receiver.
// Holds the opcode map, payload lengths and the transmitter FSM states.
package derial_pkg;

    localparam int unsigned OPCODE_W = 4;

    localparam logic [3:0]  OPCODE_RECEIVE_VALID_MOVE = 4'd0;
    localparam int unsigned LEN_VALID_MOVE            = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_GAP  = 2'd3
    } tx_state_t;

    // True for opcodes the link knows how to carry.
    function automatic logic opcode_valid(input logic [3:0] opcode);
        return (opcode == OPCODE_RECEIVE_VALID_MOVE);
    endfunction

    // Number of payload bits that follow the opcode; 0 for unknown opcodes.
    function automatic int unsigned payload_len(input logic [3:0] opcode);
        if (opcode == OPCODE_RECEIVE_VALID_MOVE) begin
            return LEN_VALID_MOVE;
        end
        return 0;
    endfunction

endpackage

// File: rtl/derial_tick_gen.sv
// derial_tick_gen: free-running divider that pulses o_tick for one cycle
// every CLK_DIV enabled cycles. i_clear restarts the count so the first
// tick after a frame accept lands exactly CLK_DIV cycles later.
module derial_tick_gen #(
    parameter int unsigned CLK_DIV = 50
) (
    input  logic clock,
    input  logic reset_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tick
);

    localparam int unsigned      CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    assign w_last = (r_cnt == CNT_LAST);
    assign o_tick = i_enable && w_last;

    // Divider count: restart on clear, advance and wrap while enabled.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/derial_tx.sv
// derial_tx: serial transmitter for the board-to-board derial link.
// Takes one command per valid/ready handshake and shifts {opcode, payload}
// out MSB-first on ser_data with a generated ser_clk (receiver samples on
// the rising edge), then holds the lines low for a fixed inter-frame gap.
module derial_tx
    import derial_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 50,
    parameter int unsigned GAP_CYCLES = 100,
    parameter int unsigned DATA_W     = 28
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              tx_valid,
    input  logic [3:0]        tx_opcode,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    output logic              tx_done,
    output logic              tx_err,
    output logic              busy,
    output logic [7:0]        frames_sent,
    output logic              ser_clk,
    output logic              ser_data
);

    localparam int unsigned      SHIFT_W  = OPCODE_W + DATA_W;
    localparam int unsigned      BIT_W    = $clog2(SHIFT_W + 1);
    localparam int unsigned      GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    tx_state_t          r_state;
    logic [SHIFT_W-1:0] r_shift;
    logic [BIT_W-1:0]   r_bit_cnt;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic [7:0]         r_frames;
    logic               r_ser_clk;
    logic               r_ser_data;
    logic               r_tx_ready;
    logic               r_busy;
    logic               r_tx_done;
    logic               r_tx_err;

    logic               w_opcode_ok;
    logic               w_accept;
    logic               w_tick;
    logic               w_tick_en;
    logic [BIT_W-1:0]   w_len;
    logic [BIT_W-1:0]   w_shamt;
    logic [DATA_W-1:0]  w_data_aligned;
    logic [SHIFT_W-1:0] w_load;

    assign w_opcode_ok = opcode_valid(tx_opcode);
    assign w_accept    = (r_state == ST_IDLE) && tx_valid && w_opcode_ok;
    assign w_tick_en   = (r_state == ST_LOW) || (r_state == ST_HIGH);

    // Payload is right-justified on tx_data; slide it up so its first bit
    // sits just below the opcode and anything above LEN falls off the top.
    assign w_len          = BIT_W'(payload_len(tx_opcode));
    assign w_shamt        = BIT_W'(DATA_W) - w_len;
    assign w_data_aligned = tx_data << w_shamt;
    assign w_load         = {tx_opcode, w_data_aligned};

    derial_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clock    (clock),
        .reset_n  (reset_n),
        .i_clear  (w_accept),
        .i_enable (w_tick_en),
        .o_tick   (w_tick)
    );

    // Frame sequencer: accept, shift each bit through a LOW then HIGH
    // half-period, then hold an idle-low gap before the next accept.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_gap_cnt  <= '0;
            r_frames   <= '0;
            r_ser_clk  <= 1'b0;
            r_ser_data <= 1'b0;
            r_tx_ready <= 1'b1;
            r_busy     <= 1'b0;
            r_tx_done  <= 1'b0;
            r_tx_err   <= 1'b0;
        end else begin
            r_tx_done <= 1'b0;
            r_tx_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (tx_valid) begin
                        if (w_opcode_ok) begin
                            r_shift    <= w_load;
                            r_bit_cnt  <= BIT_W'(OPCODE_W) + w_len;
                            r_ser_data <= w_load[SHIFT_W-1];
                            r_ser_clk  <= 1'b0;
                            r_tx_ready <= 1'b0;
                            r_busy     <= 1'b1;
                            r_state    <= ST_LOW;
                        end else begin
                            r_tx_err <= 1'b1;
                        end
                    end
                end
                ST_LOW: begin
                    if (w_tick) begin
                        r_ser_clk <= 1'b1;
                        r_state   <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (w_tick) begin
                        r_ser_clk <= 1'b0;
                        r_bit_cnt <= r_bit_cnt - 1'b1;
                        if (r_bit_cnt == BIT_W'(1)) begin
                            r_ser_data <= 1'b0;
                            r_gap_cnt  <= '0;
                            r_tx_done  <= 1'b1;
                            r_frames   <= r_frames + 1'b1;
                            r_state    <= ST_GAP;
                        end else begin
                            // Data moves only on the falling edge of ser_clk.
                            r_shift    <= {r_shift[SHIFT_W-2:0], 1'b0};
                            r_ser_data <= r_shift[SHIFT_W-2];
                            r_state    <= ST_LOW;
                        end
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        r_tx_ready <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= ST_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_ready    = r_tx_ready;
    assign tx_done     = r_tx_done;
    assign tx_err      = r_tx_err;
    assign busy        = r_busy;
    assign frames_sent = r_frames;
    assign ser_clk     = r_ser_clk;
    assign ser_data    = r_ser_data;

endmodule

// File: tb/tb_derial_tx.sv
// tb_derial_tx: self-checking bench for derial_tx (CLK_DIV=2, GAP_CYCLES=4).
module tb_derial_tx;

    localparam int unsigned CLK_DIV    = 2;
    localparam int unsigned GAP_CYCLES = 4;
    localparam int unsigned DATA_W     = 28;

    logic              clock     = 1'b0;
    logic              reset_n   = 1'b1;
    logic              tx_valid  = 1'b0;
    logic [3:0]        tx_opcode = 4'd0;
    logic [DATA_W-1:0] tx_data   = '0;
    logic              tx_ready;
    logic              tx_done;
    logic              tx_err;
    logic              busy;
    logic [7:0]        frames_sent;
    logic              ser_clk;
    logic              ser_data;

    derial_tx #(
        .CLK_DIV    (CLK_DIV),
        .GAP_CYCLES (GAP_CYCLES),
        .DATA_W     (DATA_W)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .tx_valid    (tx_valid),
        .tx_opcode   (tx_opcode),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .tx_done     (tx_done),
        .tx_err      (tx_err),
        .busy        (busy),
        .frames_sent (frames_sent),
        .ser_clk     (ser_clk),
        .ser_data    (ser_data)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Link-side observer: what a receiver would latch on each ser_clk rise.
    logic prev_sclk = 1'b0;
    logic prev_sdata = 1'b0;
    int   mon_rises = 0;
    int   mon_unstable = 0;
    bit   cap_q[$];

    always @(negedge clock) begin
        if (ser_clk && !prev_sclk) begin
            mon_rises++;
            cap_q.push_back(ser_data);
        end
        if (ser_clk && prev_sclk && (ser_data !== prev_sdata)) mon_unstable++;
        prev_sclk  = ser_clk;
        prev_sdata = ser_data;
    end

    // Reference model: frame = opcode then LEN payload bits, MSB first.
    int model_frames = 0;

    function automatic int model_len(input logic [3:0] op);
        return (op == 4'd0) ? 10 : -1;
    endfunction

    function automatic logic [31:0] model_bits(input logic [3:0] op, input logic [DATA_W-1:0] d, input int len);
        logic [31:0] mask;
        mask = (32'd1 << len) - 32'd1;
        return (32'(op) << len) | (32'(d) & mask);
    endfunction

    // Per-frame observations.
    int          f_rises, f_done_at, f_ready_at, f_err_at;
    int          f_err_pulses, f_done_pulses, f_gap_low, f_unstable, f_ready_drop;
    logic [31:0] f_bits;

    // Caller is positioned just after a negedge. k counts visible states
    // after the handshake edge (k=0 is the first cycle after it).
    task automatic do_frame(input logic [3:0] op, input logic [DATA_W-1:0] data, input bit hold);
        int r0, q0, u0;
        tx_valid  = 1'b1;
        tx_opcode = op;
        tx_data   = data;
        r0 = mon_rises;
        q0 = cap_q.size();
        u0 = mon_unstable;
        f_done_at = -1; f_ready_at = -1; f_err_at = -1;
        f_err_pulses = 0; f_done_pulses = 0; f_gap_low = 0; f_ready_drop = 0;
        @(posedge clock);
        @(negedge clock); #1;
        for (int k = 0; k < 400; k++) begin
            if (hold) begin
                tx_valid  = 1'b1;
                tx_opcode = 4'($urandom);
                tx_data   = DATA_W'($urandom);
            end else begin
                tx_valid = 1'b0;
            end
            if (tx_err) begin
                f_err_pulses++;
                if (f_err_at < 0) f_err_at = k;
            end
            if (tx_done) begin
                f_done_pulses++;
                if (f_done_at < 0) f_done_at = k;
            end
            if (f_done_pulses > 0 && busy && !ser_clk && !ser_data) f_gap_low++;
            if (tx_ready) begin
                f_ready_at = k;
                break;
            end
            @(negedge clock); #1;
        end
        if (f_ready_at == 0) begin
            tx_valid = 1'b0;
            for (int k = 1; k <= 8; k++) begin
                @(negedge clock); #1;
                if (tx_err)    f_err_pulses++;
                if (tx_done)   f_done_pulses++;
                if (!tx_ready) f_ready_drop++;
            end
        end
        f_rises    = mon_rises - r0;
        f_unstable = mon_unstable - u0;
        f_bits     = '0;
        for (int i = q0; i < cap_q.size(); i++) f_bits = {f_bits[30:0], cap_q[i]};
    endtask

    task automatic check_valid(input string name, input logic [31:0] exp_bits, input int len);
        int nbits;
        nbits = 4 + len;
        model_frames++;
        check({name, "_bits"},       f_bits, exp_bits);
        check({name, "_rises"},      f_rises, nbits);
        check({name, "_done_at"},    f_done_at, nbits * 2 * CLK_DIV);
        check({name, "_done_count"}, f_done_pulses, 1);
        check({name, "_ready_at"},   f_ready_at, nbits * 2 * CLK_DIV + GAP_CYCLES);
        check({name, "_gap_low"},    f_gap_low, GAP_CYCLES);
        check({name, "_stable"},     f_unstable, 0);
        check({name, "_no_err"},     f_err_pulses, 0);
        check({name, "_frames"},     frames_sent, model_frames % 256);
    endtask

    task automatic check_reject(input string name);
        check({name, "_err_at"},     f_err_at, 0);
        check({name, "_err_count"},  f_err_pulses, 1);
        check({name, "_rises"},      f_rises, 0);
        check({name, "_no_done"},    f_done_pulses, 0);
        check({name, "_ready_held"}, f_ready_drop, 0);
        check({name, "_frames"},     frames_sent, model_frames % 256);
    endtask

    typedef struct {
        logic [3:0]        op;
        logic [DATA_W-1:0] data;
        logic              exp_err;
        logic [13:0]       exp_bits;
    } vec_t;

    initial begin
        vec_t        tab[7];
        logic [3:0]  op;
        logic [DATA_W-1:0] d;
        int          len, r0, w;

        // Asynchronous reset: outputs take reset values without a clock edge.
        #2 reset_n = 1'b0;
        #1;
        check("reset_outputs", {ser_clk, ser_data, tx_ready, busy, tx_done, tx_err, frames_sent},
              {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0});
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock); #1;
        check("ready_after_reset", tx_ready, 1'b1);

        tab[0] = '{4'd0, 28'h00002B5, 1'b0, 14'h02B5};
        tab[1] = '{4'd0, 28'hFFFFC00, 1'b0, 14'h0000};
        tab[2] = '{4'd0, 28'h00003FF, 1'b0, 14'h03FF};
        tab[3] = '{4'd0, 28'h0000200, 1'b0, 14'h0200};
        tab[4] = '{4'd5, 28'h1234567, 1'b1, 14'h0000};
        tab[5] = '{4'hF, 28'hFFFFFFF, 1'b1, 14'h0000};
        tab[6] = '{4'd0, 28'hABCD001, 1'b0, 14'h0001};
        for (int i = 0; i < 7; i++) begin
            do_frame(tab[i].op, tab[i].data, 1'b0);
            if (tab[i].exp_err) check_reject($sformatf("tab%0d", i));
            else                check_valid($sformatf("tab%0d", i), 32'(tab[i].exp_bits), 10);
        end

        // Valid held high with scrambled inputs throughout the frame.
        do_frame(4'd0, 28'h0000155, 1'b1);
        check_valid("hold_first", model_bits(4'd0, 28'h0000155, 10), 10);
        do_frame(4'd0, 28'h00000AA, 1'b0);
        check_valid("hold_second", model_bits(4'd0, 28'h00000AA, 10), 10);

        // Randomized commands against the model.
        for (int i = 0; i < 40; i++) begin
            op  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0;
            d   = DATA_W'($urandom);
            len = model_len(op);
            do_frame(op, d, 1'b0);
            if (len < 0) check_reject($sformatf("rnd%0d", i));
            else         check_valid($sformatf("rnd%0d", i), model_bits(op, d, len), len);
        end

        // Reset after five bits: lines drop at once, next frame is whole.
        tx_valid  = 1'b1;
        tx_opcode = 4'd0;
        tx_data   = 28'h00002B5;
        r0 = mon_rises;
        @(posedge clock);
        @(negedge clock); #1;
        tx_valid = 1'b0;
        w = 0;
        while ((mon_rises - r0) < 5 && w < 200) begin
            @(negedge clock); #1;
            w++;
        end
        check("abort_rises_before", mon_rises - r0, 5);
        check("abort_lines_before", {ser_clk, ser_data}, 2'b11);
        reset_n = 1'b0;
        #1;
        check("abort_reset_outputs", {ser_clk, ser_data, tx_ready, busy, tx_done, tx_err, frames_sent},
              {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0});
        model_frames = 0;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock); #1;
        check("abort_ready_after", tx_ready, 1'b1);
        do_frame(4'd0, 28'h00002B5, 1'b0);
        check_valid("abort_next", 32'h000002B5, 10);

        // Back-to-back frames until the counter wraps past 255.
        for (int i = 0; i < 255; i++) begin
            d = DATA_W'($urandom);
            do_frame(4'd0, d, 1'b0);
            check_valid($sformatf("b2b%0d", i), model_bits(4'd0, d, 10), 10);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
